// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle sequencer for a single-channel PWM core: ramps or breathes the on-time,
// stepping only at period boundaries so the core never sees a mid-period duty change.
module pwm_fade_sequencer #(
  parameter int DUTY_W = 8,
  parameter int PERIOD = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cycle_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DUTY_W-1:0] cmd_step,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RAMP, BRTH_UP, BRTH_DN} state_t;

  localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] stp_q, stp_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // One extra bit keeps duty+stp from wrapping before it is compared.
  logic [DUTY_W:0] duty_x, tgt_x, stp_x, sum_x, dec_x, diff_x;
  logic            accept;

  assign duty_x = {1'b0, duty_q};
  assign tgt_x  = {1'b0, tgt_q};
  assign stp_x  = {1'b0, stp_q};
  assign sum_x  = duty_x + stp_x;
  assign dec_x  = duty_x - stp_x;
  assign diff_x = (duty_x > tgt_x) ? (duty_x - tgt_x) : (tgt_x - duty_x);

  assign cmd_ready = !rst && (state_q != RAMP);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    done_d  = 1'b0;
    // A new command takes priority; a coincident period end is dropped.
    if (accept) begin
      tgt_d   = (cmd_target > PERIOD_D) ? PERIOD_D : cmd_target;
      stp_d   = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;
      state_d = cmd_mode ? BRTH_UP : RAMP;
    end else if (cycle_done) begin
      case (state_q)
        RAMP: begin
          if (diff_x <= stp_x) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (duty_x < tgt_x) begin
            duty_d = sum_x[DUTY_W-1:0];
          end else begin
            duty_d = dec_x[DUTY_W-1:0];
          end
        end
        BRTH_UP: begin
          if (sum_x >= tgt_x) begin
            duty_d  = tgt_q;
            state_d = BRTH_DN;
          end else begin
            duty_d = sum_x[DUTY_W-1:0];
          end
        end
        BRTH_DN: begin
          if (duty_x <= stp_x) begin
            duty_d  = '0;
            state_d = BRTH_UP;
          end else begin
            duty_d = dec_x[DUTY_W-1:0];
          end
        end
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      stp_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus random traffic, all checked
// against a behavioural model of the fade rules.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cycle_done = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_mode = 1'b0;
  logic [7:0] cmd_target = '0;
  logic [7:0] cmd_step = '0;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a fade is either inactive, a ramp, or a breathe going up/down.
  int m_duty = 0, m_tgt = 0, m_stp = 1;
  bit m_active = 0, m_breathe = 0, m_rising = 0, m_done = 0;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(.DUTY_W(8), .PERIOD(50)) dut (
    .clk(clk), .rst(rst), .cycle_done(cycle_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_target(cmd_target), .cmd_step(cmd_step),
    .duty(duty), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit r);
    return !r && !(m_active && !m_breathe);
  endfunction

  function automatic void model_clock(input bit r, input bit cd, input bit v,
                                      input bit md, input int tg, input int sp);
    bit rdy;
    int gap;
    rdy    = model_ready(r);
    m_done = 0;
    if (r) begin
      m_duty = 0; m_active = 0; m_breathe = 0; m_rising = 0;
    end else if (v && rdy) begin
      m_tgt     = (tg > 50) ? 50 : tg;
      m_stp     = (sp == 0) ? 1 : sp;
      m_active  = 1;
      m_breathe = md;
      m_rising  = 1;
    end else if (cd && m_active) begin
      if (!m_breathe) begin
        gap = (m_tgt > m_duty) ? m_tgt - m_duty : m_duty - m_tgt;
        if (gap <= m_stp) begin
          m_duty = m_tgt; m_active = 0; m_done = 1;
        end else if (m_duty < m_tgt) m_duty += m_stp;
        else m_duty -= m_stp;
      end else if (m_rising) begin
        if (m_duty + m_stp >= m_tgt) begin m_duty = m_tgt; m_rising = 0; end
        else m_duty += m_stp;
      end else begin
        if (m_duty <= m_stp) begin m_duty = 0; m_rising = 1; end
        else m_duty -= m_stp;
      end
    end
  endfunction

  // One clock: drive on the falling edge, check ready before the rising edge and
  // registered outputs just after it.
  task automatic cyc(input bit r, input bit cd, input bit v, input bit md,
                     input int tg, input int sp);
    @(negedge clk);
    rst = r; cycle_done = cd; cmd_valid = v; cmd_mode = md;
    cmd_target = tg[7:0]; cmd_step = sp[7:0];
    #1;
    check("cmd_ready", int'(cmd_ready), int'(model_ready(r)));
    model_clock(r, cd, v, md, tg, sp);
    @(posedge clk);
    #1;
    check("duty", int'(duty), m_duty);
    check("busy", int'(busy), int'(m_active));
    check("done", int'(done), int'(m_done));
  endtask

  task automatic pulse();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    int done_cnt;
    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    check("rst_duty", int'(duty), 0);
    check("rst_ready", int'(cmd_ready), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("post_rst_ready", int'(cmd_ready), 1);

    // Ramp up 0 -> 20 by 5.
    cyc(0, 0, 1, 0, 20, 5);
    for (int i = 1; i <= 4; i++) begin
      pulse();
      check("ramp_up_duty", int'(duty), 5 * i);
    end
    check("ramp_up_done", int'(done), 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("ramp_up_idle", int'(busy), 0);

    // Clamped target with step 0, then ramp down.
    cyc(0, 0, 1, 0, 200, 0);
    for (int i = 0; i < 30; i++) pulse();
    check("clamp_duty", int'(duty), 50);
    check("clamp_done", int'(done), 1);
    cyc(0, 0, 1, 0, 3, 10);
    for (int i = 0; i < 5; i++) pulse();
    check("ramp_dn_duty", int'(duty), 3);
    check("ramp_dn_done", int'(done), 1);

    // Back to zero, then breathe 0..12 by 5 and preempt while falling.
    cyc(0, 0, 1, 0, 0, 50);
    pulse();
    cyc(0, 0, 1, 1, 12, 5);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pulse();
      done_cnt += int'(done);
    end
    check("breathe_duty", int'(duty), 7);
    check("breathe_no_done", done_cnt, 0);
    cyc(0, 0, 1, 0, 4, 1);
    for (int i = 0; i < 3; i++) pulse();
    check("preempt_duty", int'(duty), 4);
    check("preempt_done", int'(done), 1);

    // Accept and period end together; then a command held while ramping.
    cyc(0, 1, 1, 0, 10, 2);
    check("collide_duty", int'(duty), 4);
    pulse();
    cyc(0, 0, 1, 0, 30, 30);
    check("held_ready", int'(cmd_ready), 0);
    check("held_duty", int'(duty), 6);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 30, 30);
    cyc(0, 0, 1, 0, 30, 30);
    cyc(0, 1, 0, 0, 0, 0);
    check("held_applied", int'(duty), 30);

    // Reset in the middle of a ramp.
    cyc(0, 0, 1, 0, 0, 50);
    pulse();
    cyc(0, 0, 1, 0, 40, 5);
    for (int i = 0; i < 3; i++) pulse();
    check("mid_ramp_duty", int'(duty), 15);
    cyc(1, 1, 0, 0, 0, 0);
    check("mid_rst_duty", int'(duty), 0);
    check("mid_rst_done", int'(done), 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("mid_rst_idle", int'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, cd, v, md;
      int tg, sp;
      r  = ($urandom_range(0, 199) == 0);
      cd = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 9) == 0);
      md = $urandom_range(0, 1);
      tg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 55);
      sp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      cyc(r, cd, v, md, tg, sp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
